// File: rtl/parity_sched_pkg.sv
// Shared types and default sizing for the parity frame scheduler.
package parity_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/parity_frame_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index of the first request at or above ptr_i.
module rr_arbiter
    import parity_sched_pkg::*;
#(
    parameter  int N  = NREQ_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand_s;

    // Walk upward from the pointer with wrap; the first asserted request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand_s]) begin
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
                any_o           = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/parity_frame_sched.sv
// Arbitrates frames from NREQ requesters, streams each one MSB-first to a serial
// parity engine and returns the result. Optional shadow check: PARITY_SCHED_CHECK_EN.
module parity_frame_sched
    import parity_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      eng_clr,
    output logic                      eng_bit,
    output logic                      eng_bit_vld,
    input  logic                      eng_p,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      rsp_parity,
    output logic                      rsp_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH);

    sched_state_t    state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   rr_ptr_d;
    logic [IW-1:0]   id_q;
    logic [WIDTH-1:0] frame_q;
    logic [CW-1:0]   cnt_q;
    logic            eng_clr_q;
    logic            eng_bit_q;
    logic            eng_bit_vld_q;
    logic            rsp_valid_q;
    logic [IW-1:0]   rsp_id_q;
    logic            rsp_parity_q;
    logic            rsp_err_q;

    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   win_idx_s;
    logic            win_any_s;
    logic [WIDTH-1:0] win_frame_s;
    logic            idle_s;
    logic            accept_s;
    logic            shadow_err_s;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (win_idx_s),
        .any_o   (win_any_s)
    );

    // Ready is gated by reset too, so it reads zero while reset is held.
    assign idle_s   = (state_q == ST_IDLE) && reset;
    assign accept_s = idle_s && win_any_s;

    // Grant is only exposed while idle.
    always_comb begin
        if (idle_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Pick the winning frame out of the flat data bus.
    always_comb begin
        win_frame_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == IW'(i)) begin
                win_frame_s = req_data[i*WIDTH +: WIDTH];
            end else begin
                win_frame_s = win_frame_s;
            end
        end
    end

    // Pointer moves to just past the accepted requester.
    always_comb begin
        if (win_idx_s == IW'(NREQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = win_idx_s + IW'(1);
        end
    end

`ifdef PARITY_SCHED_CHECK_EN
    logic shadow_q;

    // Independent XOR of the bits actually sent, compared against the engine in CAPT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= 1'b0;
        end else if (state_q == ST_CLR) begin
            shadow_q <= 1'b0;
        end else if (eng_bit_vld_q) begin
            shadow_q <= shadow_q ^ eng_bit_q;
        end else begin
            shadow_q <= shadow_q;
        end
    end

    assign shadow_err_s = shadow_q ^ eng_p;
`else
    assign shadow_err_s = 1'b0;
`endif

    // Scheduler FSM; every output is a flop set on the transition into its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            frame_q       <= '0;
            cnt_q         <= '0;
            eng_clr_q     <= 1'b0;
            eng_bit_q     <= 1'b0;
            eng_bit_vld_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_parity_q  <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        frame_q   <= win_frame_s;
                        id_q      <= win_idx_s;
                        rr_ptr_q  <= rr_ptr_d;
                        eng_clr_q <= 1'b1;
                        state_q   <= ST_CLR;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    eng_clr_q     <= 1'b0;
                    eng_bit_vld_q <= 1'b1;
                    eng_bit_q     <= frame_q[WIDTH-1];
                    frame_q       <= {frame_q[WIDTH-2:0], 1'b0};
                    cnt_q         <= CW'(WIDTH - 1);
                    state_q       <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // cnt_q counts the bits still to follow the one on the wire.
                    if (cnt_q == '0) begin
                        eng_bit_vld_q <= 1'b0;
                        eng_bit_q     <= 1'b0;
                        state_q       <= ST_CAPT;
                    end else begin
                        eng_bit_q     <= frame_q[WIDTH-1];
                        frame_q       <= {frame_q[WIDTH-2:0], 1'b0};
                        cnt_q         <= cnt_q - CW'(1);
                    end
                end
                ST_CAPT: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= id_q;
                    rsp_parity_q <= eng_p;
                    rsp_err_q    <= shadow_err_s;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        rsp_id_q     <= '0;
                        rsp_parity_q <= 1'b0;
                        rsp_err_q    <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q      <= ST_RESP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng_clr     = eng_clr_q;
    assign eng_bit     = eng_bit_q;
    assign eng_bit_vld = eng_bit_vld_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_parity  = rsp_parity_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_parity_frame_sched.sv
// Self-checking bench for parity_frame_sched with an XOR engine model and a
// round-robin / parity reference model.
module tb_parity_frame_sched;

    localparam int N = 4;
    localparam int W = 3;
`ifdef PARITY_SCHED_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           eng_clr;
    logic           eng_bit;
    logic           eng_bit_vld;
    logic           eng_p;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic           rsp_parity;
    logic           rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    int clr_cnt  = 0;
    bit inv_en   = 1'b0;
    bit inv_on   = 1'b0;
    bit bits[$];
    logic eng_par_q;

    parity_frame_sched #(.NREQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .eng_clr     (eng_clr),
        .eng_bit     (eng_bit),
        .eng_bit_vld (eng_bit_vld),
        .eng_p       (eng_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_parity  (rsp_parity),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial XOR engine; the inversion hook corrupts its answer on demand.
    always @(posedge clk or negedge reset) begin
        if (!reset)           eng_par_q <= 1'b0;
        else if (eng_clr)     eng_par_q <= 1'b0;
        else if (eng_bit_vld) eng_par_q <= eng_par_q ^ eng_bit;
    end
    assign eng_p = eng_par_q ^ inv_on;

    always @(posedge clk) begin
        if (eng_bit_vld) bits.push_back(eng_bit);
        if (eng_clr) clr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One full transaction from the current negedge: accept, stream, response, handshake.
    task automatic run_txn(input int hold, input bit imm, output int got_id);
        int waited;
        int lat;
        int exp_id;
        logic [W-1:0] frm;
        logic exp_par;
        logic exp_err;
        waited = 0;
        got_id = -1;
        #1;
        while ((req_valid & req_ready) == '0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("accept_seen", 32'(waited < 20), 32'd1);
        if (waited >= 20) return;
        if (imm) chk("accept_gap", waited, 32'd0);
        exp_id = rr_pick(req_valid, ptr_m);
        chk("grant_onehot", req_ready, 32'd1 << exp_id);
        got_id  = exp_id;
        frm     = W'(req_data >> (exp_id * W));
        ptr_m   = (exp_id + 1) % N;
        inv_on  = inv_en && (frm == {W{1'b1}});
        exp_par = (^frm) ^ inv_on;
        exp_err = CHECK_EN & inv_on;
        bits.delete();
        clr_cnt = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid) chk("ready_busy", req_ready, 32'd0);
        end while (!rsp_valid && lat < 30);
        chk("latency", lat, W + 3);
        chk("bit_count", bits.size(), W);
        for (int i = 0; i < W && i < bits.size(); i++) chk("bit_stream", bits[i], frm[W-1-i]);
        chk("clr_pulses", clr_cnt, 32'd1);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_parity", rsp_parity, exp_par);
        chk("rsp_err", rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 32'd1);
            chk("bp_id", rsp_id, exp_id);
            chk("bp_parity", rsp_parity, exp_par);
            chk("bp_err", rsp_err, exp_err);
            chk("bp_ready", req_ready, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        inv_on    = 1'b0;
        chk("rsp_drop", rsp_valid, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 32'd0);
        chk({tag, "_eng_clr"}, eng_clr, 32'd0);
        chk({tag, "_eng_bit"}, eng_bit, 32'd0);
        chk({tag, "_eng_bit_vld"}, eng_bit_vld, 32'd0);
        chk({tag, "_rsp_valid"}, rsp_valid, 32'd0);
        chk({tag, "_rsp_id"}, rsp_id, 32'd0);
        chk({tag, "_rsp_parity"}, rsp_parity, 32'd0);
        chk({tag, "_rsp_err"}, rsp_err, 32'd0);
    endtask

    initial begin
        int id;
        int n;
        int fair_exp[5];
        fair_exp = '{0, 1, 2, 3, 0};
        reset     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");

        // Single request from requester 0 with frame 101.
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b0001;
        req_data  = {3'b011, 3'b110, 3'b010, 3'b101};
        run_txn(0, 1'b0, id);
        chk("single_id", id, 32'd0);

        // Backpressure with everyone requesting, then an immediate follow-on accept.
        req_valid = 4'b1111;
        req_data  = 12'($urandom);
        run_txn(5, 1'b0, id);
        chk("bp_order", id, 32'd1);
        run_txn(0, 1'b1, id);
        chk("bp_next", id, 32'd2);

        // Reset asserted after the second shifted bit of requester 3's frame.
        req_valid = 4'b1000;
        #1;
        chk("rst_pre_accept", req_ready, 32'b1000);
        bits.delete();
        n = 0;
        while (bits.size() < 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_two_bits", bits.size(), 32'd2);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_async");
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", rsp_valid, 32'd0);
        end
        ptr_m = 0;

        // Fairness right after reset release: 0,1,2,3,0, back to back.
        req_valid = 4'b1111;
        req_data  = 12'($urandom);
        reset     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, i > 0, id);
            chk("fair_order", id, fair_exp[i]);
        end

        // Engine corrupts its answer for frame 111.
        inv_en    = 1'b1;
        req_valid = 4'b1000;
        req_data  = {3'b111, 9'($urandom)};
        run_txn(2, 1'b0, id);
        chk("inject_id", id, 32'd3);
        inv_en = 1'b0;

        // Randomised traffic against the reference model.
        for (int i = 0; i < 12; i++) begin
            req_valid = 4'($urandom_range(1, 15));
            req_data  = 12'($urandom);
            run_txn($urandom_range(0, 3), 1'b0, id);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_sched.md
PARITY_FRAME_SCHED -- requirements
Module: parity_frame_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 3, bits per frame (2..16).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester frame offer.
REQ-006 req_data  input  NREQ*WIDTH  frames, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  NREQ  one-hot accept; a frame is taken when req_valid[i] & req_ready[i].
REQ-008 eng_clr  output  1  one-cycle restart pulse to the serial parity engine.
REQ-009 eng_bit  output  1  serial bit to the engine.
REQ-010 eng_bit_vld  output  1  eng_bit qualifier.
REQ-011 eng_p  input  1  engine parity result, valid the cycle after the last bit.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  result consumed when rsp_valid & rsp_ready.
REQ-014 rsp_id  output  $clog2(NREQ)  index of the requester that owns the result.
REQ-015 rsp_parity  output  1  sampled eng_p.
REQ-016 rsp_err  output  1  shadow-check mismatch (0 when the check is compiled out).

Function
REQ-017 The FSM SHALL have the states IDLE, CLR, SHIFT, CAPT and RESP.
REQ-018 IDLE: req_ready SHALL be one-hot on the round-robin winner among asserted req_valid bits, searching upward from pointer rr_ptr; all zero if no request.
REQ-019 On accept, the block SHALL latch the frame and id, set rr_ptr = (id+1) mod NREQ, and go to CLR.
REQ-020 CLR: eng_clr=1 for exactly one cycle; then SHIFT.
REQ-021 SHIFT: eng_bit_vld=1 for exactly WIDTH consecutive cycles, MSB first; after the last bit, CAPT.
REQ-022 CAPT: the block SHALL sample eng_p into rsp_parity and go to RESP.
REQ-023 RESP: rsp_valid=1 with stable rsp_id/rsp_parity/rsp_err until rsp_ready; on handshake, IDLE.
REQ-024 Latency: accept at edge t SHALL produce rsp_valid high from edge t+WIDTH+3.
REQ-025 No bypass: a request pending during the RESP handshake cycle SHALL be accepted no earlier than the following IDLE cycle.
REQ-026 req_ready SHALL be zero in every state except IDLE; a withdrawn req_valid before accept has no effect.
REQ-027 Outside SHIFT, eng_bit and eng_bit_vld SHALL be 0; outside CLR, eng_clr SHALL be 0.

Reset
REQ-028 Reset asserted SHALL immediately force IDLE, rr_ptr=0, and all outputs to 0, including during SHIFT or RESP; the in-flight frame is discarded.
REQ-029 The first accept after reset deassertion SHALL favour requester 0.

Configuration
REQ-030 With PARITY_SCHED_CHECK_EN defined, the block SHALL keep a shadow XOR of the shifted bits and set rsp_err = (shadow != eng_p) in CAPT.
REQ-031 Without PARITY_SCHED_CHECK_EN, rsp_err SHALL be tied 0 and the shadow logic SHALL be absent.

Structure
REQ-032 Package parity_sched_pkg SHALL hold the state enum and the NREQ/WIDTH default constants.
REQ-033 Round-robin selection SHALL live in sub-module rr_arbiter (req, ptr -> one-hot grant, index).

Verification
REQ-034 Single request: req0 offers 3'b101, engine model is XOR. Required: accept at t; eng_bit stream 1,0,1; rsp_valid at t+6; rsp_id=0; rsp_parity=0.
REQ-035 Fairness: all four requesters assert continuously. Required: grant order 0,1,2,3,0, with each accept exactly one cycle after the prior response handshake.
REQ-036 Backpressure: rsp_ready held 0 for 5 cycles. Required: rsp_* outputs stable, req_ready stays 0 throughout, and the next accept occurs only after the handshake.
REQ-037 Reset mid-SHIFT: reset asserted after the 2nd bit. Required: all outputs drop to 0 asynchronously, no response is produced, and the next winner is req0.
REQ-038 With PARITY_SCHED_CHECK_EN, the engine model is forced to invert eng_p on frame 3'b111. Required: rsp_parity=0 and rsp_err=1; without the macro, rsp_err=0.
